// File: rtl/sr_latch_cmd_if.sv
// Pushbutton-to-latch command bundle for sr_latch_cmd_gen.
// SR_LATCH_CMD_MODEL_EN adds q_model, the expected latch Q.
interface sr_latch_cmd_if;
  // No valid/ready pair: buttons are raw levels; busy is high while a command
  // (setup, enable pulse, hold) is in flight, and new presses queue meanwhile.
  logic       set_btn;
  logic       reset_btn;
  logic       s;
  logic       r;
  logic       en;
  logic       busy;
  logic [1:0] state_dbg;
`ifdef SR_LATCH_CMD_MODEL_EN
  logic       q_model;

  modport slave  (input set_btn, reset_btn,
                  output s, r, en, busy, state_dbg, q_model);
  modport master (output set_btn, reset_btn,
                  input s, r, en, busy, state_dbg, q_model);
`else
  modport slave  (input set_btn, reset_btn,
                  output s, r, en, busy, state_dbg);
  modport master (output set_btn, reset_btn,
                  input s, r, en, busy, state_dbg);
`endif
endinterface

// File: rtl/sr_latch_cmd_gen.sv
// Synchronize, debounce and edge-detect two pushbuttons, then sequence clean
// s/r/en commands for a gated SR latch. SR_LATCH_CMD_MODEL_EN adds q_model.
module sr_latch_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EN_PULSE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  sr_latch_cmd_if.slave   bus
);

  localparam int DW = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = ($clog2(EN_PULSE_CYCLES + 1) < 1) ? 1 : $clog2(EN_PULSE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  // Bit 0 tracks the set button, bit 1 the reset button.
  logic [1:0]    meta_q, meta_d;
  logic [1:0]    sync_q, sync_d;
  logic [1:0]    db_q, db_d;
  logic [1:0]    db_prev_q, db_prev_d;
  logic [1:0]    pend_q, pend_d;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  logic [1:0]    rise;
  logic [1:0]    served;
  logic          idle;

  state_t        state_q;
  logic [PW-1:0] pcnt_q;
  logic          s_q, r_q, en_q, busy_q;

  assign idle   = (state_q == IDLE);
  // Reset has priority; only the flag actually served is cleared.
  assign served = {idle & pend_q[1], idle & ~pend_q[1] & pend_q[0]};
  assign rise   = db_q & ~db_prev_q;

  always_comb begin
    meta_d    = {bus.reset_btn, bus.set_btn};
    sync_d    = meta_q;
    db_d      = db_q;
    db_prev_d = db_q;
    pend_d    = (pend_q & ~served) | rise;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != db_q[i]) begin
        if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= '0;
      sync_q    <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      pend_q    <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      pend_q    <= pend_d;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
    end
  end

`ifdef SR_LATCH_CMD_MODEL_EN
  logic q_model_q;
`endif

  // s/r are only changed on entry to SETUP and on leaving HOLD, never while en=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SR_LATCH_CMD_MODEL_EN
      q_model_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_q[1] || pend_q[0]) begin
            state_q <= SETUP;
            s_q     <= ~pend_q[1];
            r_q     <= pend_q[1];
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          state_q <= PULSE;
          en_q    <= 1'b1;
          pcnt_q  <= '0;
        end
        PULSE: begin
          if (pcnt_q == PW'(EN_PULSE_CYCLES - 1)) begin
            state_q   <= HOLD;
            en_q      <= 1'b0;
`ifdef SR_LATCH_CMD_MODEL_EN
            q_model_q <= s_q;
`endif
          end else begin
            pcnt_q <= pcnt_q + PW'(1);
          end
        end
        HOLD: begin
          state_q <= IDLE;
          s_q     <= 1'b0;
          r_q     <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.en        = en_q;
  assign bus.busy      = busy_q;
  assign bus.state_dbg = state_q;
`ifdef SR_LATCH_CMD_MODEL_EN
  assign bus.q_model   = q_model_q;
`endif

endmodule

// File: tb/tb_sr_latch_cmd_gen.sv
// Randomized bench for sr_latch_cmd_gen: a window-based button model predicts
// each command's type and start cycle; a negedge monitor checks every cycle.
module tb_sr_latch_cmd_gen;

  localparam int DB = 4;
  localparam int EP = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  sr_latch_cmd_if bus();

  sr_latch_cmd_gen #(
    .DEBOUNCE_CYCLES(DB),
    .EN_PULSE_CYCLES(EP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Entry: {is_set, start_cycle}
  logic [32:0] exp_q[$];

  int          cyc = 0;
  int          last_start;
  bit          started;
  logic [1:0]  m_db, m_dbp, m_pend;
  logic [DB:0] hist [2];

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    tests_run++;
    if (act_v !== exp_v) begin
      tests_failed++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act_v, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic m_clear();
    started    = 1'b0;
    last_start = 0;
    m_db       = '0;
    m_dbp      = '0;
    m_pend     = '0;
    hist[0]    = '0;
    hist[1]    = '0;
  endtask

  // A debounced level flips once the last DB synchronized samples all disagree
  // with it; synchronized samples lag the pins by two edges.
  task automatic model_step();
    logic [1:0] served, rise, nd;
    bit         idle;
    cyc++;
    idle   = !started || (cyc >= last_start + EP + 3);
    served = '0;
    if (idle && m_pend[1]) begin
      served[1] = 1'b1;
      exp_q.push_back({1'b0, 32'(cyc)});
      started = 1'b1;
      last_start = cyc;
    end else if (idle && m_pend[0]) begin
      served[0] = 1'b1;
      exp_q.push_back({1'b1, 32'(cyc)});
      started = 1'b1;
      last_start = cyc;
    end
    for (int i = 0; i < 2; i++) begin
      rise[i] = m_db[i] & ~m_dbp[i];
      nd[i]   = (hist[i][DB:1] == {DB{~m_db[i]}}) ? ~m_db[i] : m_db[i];
    end
    m_pend  = (m_pend & ~served) | rise;
    m_dbp   = m_db;
    m_db    = nd;
    hist[0] = {hist[0][DB-1:0], bus.set_btn};
    hist[1] = {hist[1][DB-1:0], bus.reset_btn};
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_clear();
        exp_q.delete();
      end else begin
        model_step();
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit         act;
  bit         act_set;
  bit         busy_prev;
  bit         q_exp;
  int         off;
  logic [3:0] exp4;
  logic [32:0] e;

  initial begin
    act = 0; busy_prev = 0; q_exp = 0; off = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act       = 0;
        busy_prev = 0;
        q_exp     = 0;
      end else begin
        check("s_and_r_exclusive", 32'(bus.s & bus.r), 32'd0);
        if (bus.busy && !busy_prev) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_cmd at cyc %0d: got busy rise, expected none", cyc);
          end else begin
            e = exp_q.pop_front();
            check("cmd_start_cyc", 32'(cyc), e[31:0]);
            act     = 1;
            off     = 0;
            act_set = e[32];
          end
        end
        if (act) begin
          exp4 = {1'b1, act_set, ~act_set, (off >= 1 && off <= EP)};
          check("cmd_busy_s_r_en", 32'({bus.busy, bus.s, bus.r, bus.en}), 32'(exp4));
          if (off == EP + 1) q_exp = act_set;
          off++;
          if (off == EP + 2) act = 0;
        end else begin
          check("idle_busy_s_r_en", 32'({bus.busy, bus.s, bus.r, bus.en}), 32'd0);
        end
`ifdef SR_LATCH_CMD_MODEL_EN
        check("q_model", 32'(bus.q_model), 32'(q_exp));
`endif
        busy_prev = bus.busy;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    idle_cycles(3 * DB + 3 * (EP + 3) + 12);
  endtask

  task automatic wait_en(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.en) begin
        ok = 1;
        break;
      end
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL wait_en: en stayed 0 for 40 cycles, required 1");
    end
  endtask

  task automatic check_all_low(input string name);
    check(name, 32'({bus.busy, bus.s, bus.r, bus.en}), 32'd0);
  endtask

  bit ok;

  initial begin
    bus.set_btn   = 1'b0;
    bus.reset_btn = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_low("reset_state");
`ifdef SR_LATCH_CMD_MODEL_EN
    check("reset_q_model", 32'(bus.q_model), 32'd0);
`endif
    idle_cycles(3);
    #2 rst_n = 1'b1;
    idle_cycles(5);

    // Single clean set press
    bus.set_btn = 1'b1;
    idle_cycles(8);
    bus.set_btn = 1'b0;
    drain();

    // Bounce: toggling every cycle never settles
    for (int i = 0; i < 20; i++) begin
      bus.set_btn = ~bus.set_btn;
      idle_cycles(1);
    end
    bus.set_btn = 1'b0;
    drain();

    // Simultaneous presses: reset first, then set
    bus.set_btn   = 1'b1;
    bus.reset_btn = 1'b1;
    idle_cycles(8);
    bus.set_btn   = 1'b0;
    bus.reset_btn = 1'b0;
    drain();

    // Reset presses while a set command is in flight
    bus.set_btn = 1'b1;
    idle_cycles(DB + 3);
    bus.reset_btn = 1'b1;
    idle_cycles(DB + 1);
    bus.reset_btn = 1'b0;
    bus.set_btn   = 1'b0;
    idle_cycles(DB + 1);
    bus.reset_btn = 1'b1;
    idle_cycles(DB + 1);
    bus.reset_btn = 1'b0;
    drain();

    // Asynchronous reset while en is high
    bus.set_btn = 1'b1;
    wait_en(ok);
    #2 rst_n = 1'b0;
    bus.set_btn = 1'b0;
    #1;
    check("midcmd_reset_en", 32'(bus.en), 32'd0);
    check("midcmd_reset_s", 32'(bus.s), 32'd0);
    check("midcmd_reset_r", 32'(bus.r), 32'd0);
    check("midcmd_reset_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    drain();

    // Button held through reset release
    bus.set_btn = 1'b1;
    idle_cycles(3);
    #2 rst_n = 1'b0;
    idle_cycles(3);
    #2 rst_n = 1'b1;
    idle_cycles(15);
    bus.set_btn = 1'b0;
    drain();

    // Random button activity
    for (int i = 0; i < 200; i++) begin
      bus.set_btn   = 1'($urandom_range(0, 1));
      bus.reset_btn = 1'($urandom_range(0, 1));
      idle_cycles($urandom_range(1, 8));
    end
    bus.set_btn   = 1'b0;
    bus.reset_btn = 1'b0;
    drain();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sr_latch_cmd_gen.md
# sr_latch_cmd_gen

- Upstream driver for the gated SR latch stage.
- Turns two raw pushbutton inputs into clean, single-shot latch commands on s, r and en: synchronizes, debounces, edge-detects and queues requests.
- Sequences each command as setup, enable pulse, then hold, so the latch never sees s=r=1 or an s/r change while en is high.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles required to accept a button level change; legal range ≥1.
- EN_PULSE_CYCLES, 2: cycles en is held high per command; legal range ≥1.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- set_btn  in  1  raw asynchronous set pushbutton, active high.
- reset_btn  in  1  raw asynchronous reset pushbutton, active high.
- s  out  1  latch set input.
- r  out  1  latch reset input.
- en  out  1  latch gate enable.
- busy  out  1  high whenever FSM is not IDLE.

## Operation
- Synchronizer: two flops per button, giving set_sync and rst_sync.
- Debounce, per button:
  - Debounced level db (reset 0) and counter cnt (width $clog2(DEBOUNCE_CYCLES+1)).
  - Each edge where sync != db: cnt increments. When cnt == DEBOUNCE_CYCLES-1 on such an edge, db flips and cnt clears.
  - Any edge where sync == db: cnt clears.
- Edge detect: db_prev register. A rise (db & ~db_prev) sets pending flag set_pend or rst_pend at the next edge.
  - A rise while the same flag is already set merges; no second command.
  - Falling edges are ignored.
- FSM states: IDLE, SETUP, PULSE, HOLD.
  - IDLE: if rst_pend, load cmd=RESET. Else if set_pend, load cmd=SET. Go to SETUP and clear only the served flag on that same edge.
  - Simultaneous pending: reset wins; set stays pending and is served next.
  - SETUP (1 cycle): s=(cmd==SET), r=(cmd==RESET), en=0.
  - PULSE (EN_PULSE_CYCLES cycles, pulse counter): s/r unchanged, en=1.
  - HOLD (1 cycle): s/r unchanged, en=0. Then IDLE.
  - IDLE: s=r=en=0.
- Requests arriving while busy are queued in the pending flags and served after return to IDLE.
- Invariant: s&r is never 1; s and r never change while en=1.
- All outputs are registered.

## Timing
- Reset (async assert): s=0, r=0, en=0, busy=0. State IDLE; pending flags, db, db_prev, sync flops and counters all 0.
- Reset mid-command: en drops immediately; the command is abandoned and not replayed.
- Button held through reset release: seen as a rising edge after debounce, producing exactly one command.
- Latency, with the button first sampled high at edge k:
  - db changes at edge k+1+DEBOUNCE_CYCLES.
  - pending set at edge k+2+DEBOUNCE_CYCLES.
  - s or r asserted at edge k+3+DEBOUNCE_CYCLES.
  - en high from edge k+4+DEBOUNCE_CYCLES for EN_PULSE_CYCLES cycles.
  - s/r deassert and busy falls 1 cycle after en falls.
- Command length: 2+EN_PULSE_CYCLES cycles with busy=1. Back-to-back queued commands are separated by exactly one IDLE cycle.
- A bounce shorter than DEBOUNCE_CYCLES stable cycles produces no db change and no command.

## Configuration
- Macro SR_LATCH_CMD_MODEL_EN.
- Defined: adds output port q_model (1 bit, reset 0), the expected latch Q. It updates on the edge entering HOLD: 1 after a SET command, 0 after a RESET command. busy and all other behaviour are unchanged.
- Undefined: no q_model port, no model register; the remaining logic is identical.

## Test plan
- Reset then set_btn high at edge 10, defaults → s=1 from edge 17; en=1 on edges 18–19 (2 cycles); s=0 at edge 21; r and en stay 0 otherwise; busy high edges 17–20.
- set_btn toggles every cycle for 20 cycles then returns low → db never changes; s, r, en, busy stay 0 throughout.
- set_btn and reset_btn both rise at the same edge → RESET command first (r=1, s=0), one IDLE cycle, then SET command; s&r never 1.
- reset_btn pressed again during an active SET command → RESET runs after busy drops and one IDLE cycle. Two reset presses during one command → only one RESET.
- rst_n pulled low while en=1 → s, r, en, busy go 0 with no clock edge; after release, no further command occurs unless a new press arrives.
- With SR_LATCH_CMD_MODEL_EN defined, the sequence SET, RESET, SET → q_model reads 1, 0, 1, each value updated on HOLD entry.
